// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver: recovers active-area coordinates from a VGA-style
// sync/RGB stream. One input register stage (S1) followed by a registered
// output stage gives a fixed 2-clock pin-to-output latency.
// Optional build macro: VGA_RX_MEASURE_EN adds line/frame length
// measurement and gates/drops lock on H_TOTAL_EXP / V_TOTAL_EXP.
//
// Handshake: the output side is a pure streaming qualifier with no
// back-pressure. outValid marks a pixel inside the active window while
// locked; outX/outY/RGB carry data only when outValid=1 and are zero
// otherwise. outLineStart/outFrameStart are single-cycle pulses that only
// ever occur together with outValid.
module vga_timing_receiver #(
  parameter int X_START     = 144,
  parameter int Y_START     = 35,
  parameter int H_SYNC_ACT  = 640,
  parameter int V_SYNC_ACT  = 480,
  parameter int H_TOTAL_EXP = 800,
  parameter int V_TOTAL_EXP = 525
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       in_H_SYNC,
  input  logic       in_V_SYNC,
  input  logic [9:0] inRed,
  input  logic [9:0] inGreen,
  input  logic [9:0] inBlue,
  output logic [9:0] outRed,
  output logic [9:0] outGreen,
  output logic [9:0] outBlue,
  output logic [9:0] outX,
  output logic [9:0] outY,
  output logic       outValid,
  output logic       outLineStart,
  output logic       outFrameStart,
  output logic       outLocked,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [11:0] LP_X0  = 12'(X_START);
  localparam logic [11:0] LP_X1  = 12'(X_START + H_SYNC_ACT);
  localparam logic [11:0] LP_Y0  = 12'(Y_START);
  localparam logic [11:0] LP_Y1  = 12'(Y_START + V_SYNC_ACT);
  localparam logic [11:0] LP_SAT = 12'hFFF;

  // The expected totals must at least cover the active window.
  if (H_TOTAL_EXP < X_START + H_SYNC_ACT || V_TOTAL_EXP < Y_START + V_SYNC_ACT) begin : g_bad_totals
    $error("vga_timing_receiver: expected totals smaller than active window");
  end

  logic        r_hs1, r_vs1, r_hs_prev, r_vs_prev;
  logic [9:0]  r_red1, r_green1, r_blue1;
  logic [11:0] r_h_cnt, r_v_cnt;
  logic        r_v_pend;
  state_t      r_state;

  logic        w_h_fall, w_v_fall, w_pend_next, w_active, w_valid;
  logic [11:0] w_h_next, w_v_next;
  logic [9:0]  w_dx, w_dy;
  state_t      w_state_next;

  assign o_dbg_state = r_state;

  // S1: capture syncs and pixel data; sync history preset high so release
  // from reset never fabricates a falling edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_hs_prev <= 1'b1;
      r_vs_prev <= 1'b1;
      r_red1    <= '0;
      r_green1  <= '0;
      r_blue1   <= '0;
    end else begin
      r_hs1     <= in_H_SYNC;
      r_vs1     <= in_V_SYNC;
      r_hs_prev <= r_hs1;
      r_vs_prev <= r_vs1;
      r_red1    <= inRed;
      r_green1  <= inGreen;
      r_blue1   <= inBlue;
    end
  end

  // Counter, edge and window decode for the pixel currently held in S1.
  always_comb begin
    w_h_fall = r_hs_prev & ~r_hs1;
    w_v_fall = r_vs_prev & ~r_vs1;
    w_h_next = w_h_fall ? 12'd0 : ((r_h_cnt == LP_SAT) ? LP_SAT : r_h_cnt + 12'd1);
    w_v_next = r_v_cnt;
    if (w_h_fall) begin
      if (r_v_pend || w_v_fall) w_v_next = 12'd0;
      else if (r_v_cnt != LP_SAT) w_v_next = r_v_cnt + 12'd1;
    end
    w_pend_next = w_h_fall ? 1'b0 : (r_v_pend | w_v_fall);
    w_active = (w_h_next >= LP_X0) && (w_h_next < LP_X1) &&
               (w_v_next >= LP_Y0) && (w_v_next < LP_Y1);
    w_dx = 10'(w_h_next - LP_X0);
    w_dy = 10'(w_v_next - LP_Y0);
  end

`ifdef VGA_RX_MEASURE_EN
  localparam logic [12:0] LP_HEXP = 13'(H_TOTAL_EXP);
  localparam logic [12:0] LP_VEXP = 13'(V_TOTAL_EXP);
  logic [12:0] r_hmeas, r_vmeas, w_hmeas_next, w_vmeas_next;
  logic        w_h_ok, w_v_ok;

  // Line length in clocks and frame length in lines, latched at the edges
  // that close each interval.
  always_comb begin
    w_hmeas_next = w_h_fall ? {1'b0, r_h_cnt} + 13'd1 : r_hmeas;
    w_vmeas_next = (w_h_fall && (r_v_pend || w_v_fall)) ? {1'b0, r_v_cnt} + 13'd1 : r_vmeas;
    w_h_ok       = (w_hmeas_next == LP_HEXP);
    w_v_ok       = (w_vmeas_next == LP_VEXP);
  end

  // Measurement registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_hmeas <= '0;
      r_vmeas <= '0;
    end else begin
      r_hmeas <= w_hmeas_next;
      r_vmeas <= w_vmeas_next;
    end
  end
`endif

  // Lock state decision; losing hsync (saturated H count) overrides all.
  always_comb begin
    w_state_next = r_state;
    if (w_h_next == LP_SAT) begin
      w_state_next = SEARCH;
    end else begin
      case (r_state)
        SEARCH: if (w_v_fall) w_state_next = ALIGN;
`ifdef VGA_RX_MEASURE_EN
        ALIGN:  if (w_v_fall && w_h_ok && w_v_ok) w_state_next = LOCKED;
        LOCKED: if ((w_h_fall && !w_h_ok) || (w_v_fall && !w_v_ok)) w_state_next = SEARCH;
`else
        ALIGN:  if (w_v_fall) w_state_next = LOCKED;
        LOCKED: w_state_next = LOCKED;
`endif
        default: w_state_next = SEARCH;
      endcase
    end
    w_valid = w_active && (w_state_next == LOCKED);
  end

  // Lock FSM, counters and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state       <= SEARCH;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_v_pend      <= 1'b0;
      outLocked     <= 1'b0;
      outValid      <= 1'b0;
      outLineStart  <= 1'b0;
      outFrameStart <= 1'b0;
      outX          <= '0;
      outY          <= '0;
      outRed        <= '0;
      outGreen      <= '0;
      outBlue       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_h_cnt       <= w_h_next;
      r_v_cnt       <= w_v_next;
      r_v_pend      <= w_pend_next;
      outLocked     <= (w_state_next == LOCKED);
      outValid      <= w_valid;
      outLineStart  <= w_valid && (w_dx == 10'd0);
      outFrameStart <= w_valid && (w_dx == 10'd0) && (w_dy == 10'd0);
      outX          <= w_valid ? w_dx : 10'd0;
      outY          <= w_valid ? w_dy : 10'd0;
      outRed        <= w_valid ? r_red1 : 10'd0;
      outGreen      <= w_valid ? r_green1 : 10'd0;
      outBlue       <= w_valid ? r_blue1 : 10'd0;
    end
  end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// tb_vga_timing_receiver: drives scaled-down VGA frames with random or
// ramp pixel data and compares every output cycle against a reference
// model derived from cycle and edge counts.
module tb_vga_timing_receiver;

  localparam int XS = 8, YS = 3, HA = 16, VA = 6, HT = 32, VT = 12;
  localparam int HSW = 4, VSW = 2;
  localparam int W = 54;

  logic       iCLK = 1'b0, iRST_N = 1'b0, in_H_SYNC = 1'b1, in_V_SYNC = 1'b1;
  logic [9:0] inRed = '0, inGreen = '0, inBlue = '0;
  logic [9:0] outRed, outGreen, outBlue, outX, outY;
  logic       outValid, outLineStart, outFrameStart, outLocked;
  logic [1:0] o_dbg_state;

  // clock / reset
  always #5 iCLK = ~iCLK;

  vga_timing_receiver #(
    .X_START(XS), .Y_START(YS), .H_SYNC_ACT(HA), .V_SYNC_ACT(VA),
    .H_TOTAL_EXP(HT), .V_TOTAL_EXP(VT)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .in_H_SYNC(in_H_SYNC), .in_V_SYNC(in_V_SYNC),
    .inRed(inRed), .inGreen(inGreen), .inBlue(inBlue),
    .outRed(outRed), .outGreen(outGreen), .outBlue(outBlue),
    .outX(outX), .outY(outY), .outValid(outValid), .outLineStart(outLineStart),
    .outFrameStart(outFrameStart), .outLocked(outLocked), .o_dbg_state(o_dbg_state)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [9:0]   pin_red_q[$];
  int n_checks = 0, n_errors = 0;
  int valid_seen, ls_seen, fs_seen, ramp_checks;
  bit first_seen, first_fs, ramp_mode;
  logic [9:0] first_x, first_y;
  logic cur_vs = 1'b1;

  // reference model state: cycle/edge bookkeeping
  int m_cyc, m_last_hf, m_hf_cnt, m_frame_hf, m_vfalls;
  bit m_prev_hs, m_prev_vs, m_vpend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    // The reset contents of S1 count as one idle (sync-high) pixel.
    m_cyc = 1; m_last_hf = 0; m_hf_cnt = 0; m_frame_hf = 0; m_vfalls = 0;
    m_prev_hs = 1'b1; m_prev_vs = 1'b1; m_vpend = 1'b0;
  endtask

  task automatic model_pixel(input logic hs, input logic vs, input logic [9:0] r,
                             input logic [9:0] g, input logic [9:0] b,
                             output logic [W-1:0] e);
    bit hf, vf, act, val, locked;
    int h, v;
    logic [9:0] x, y;
    m_cyc++;
    hf = m_prev_hs && !hs;
    vf = m_prev_vs && !vs;
    m_prev_hs = hs;
    m_prev_vs = vs;
    if (vf) m_vpend = 1'b1;
    if (hf) begin
      m_last_hf = m_cyc;
      m_hf_cnt++;
      if (m_vpend) begin m_frame_hf = m_hf_cnt; m_vpend = 1'b0; end
    end
    h = m_cyc - m_last_hf;    if (h > 4095) h = 4095;
    v = m_hf_cnt - m_frame_hf; if (v > 4095) v = 4095;
    if (h == 4095) m_vfalls = 0;
    else if (vf) m_vfalls++;
    locked = (m_vfalls >= 2);
    act = (h >= XS) && (h < XS + HA) && (v >= YS) && (v < YS + VA);
    val = act && locked;
    x = val ? 10'(h - XS) : 10'd0;
    y = val ? 10'(v - YS) : 10'd0;
    e = {val, val && x == 0, val && x == 0 && y == 0, locked, x, y,
         val ? r : 10'd0, val ? g : 10'd0, val ? b : 10'd0};
  endtask

  task automatic check_out();
    logic [W-1:0] e, o;
    logic [9:0] pr;
    e = exp_q.pop_front();
    pr = pin_red_q.pop_front();
    o = {outValid, outLineStart, outFrameStart, outLocked, outX, outY, outRed, outGreen, outBlue};
    chk("pixel", 64'(o), 64'(e));
    if (outValid === 1'b1) begin
      valid_seen++;
      if (!first_seen) begin
        first_seen = 1; first_x = outX; first_y = outY; first_fs = outFrameStart;
      end
      if (ramp_mode && outX == 10'd0) begin
        ramp_checks++;
        chk("ramp_lag", 64'(outRed), 64'(pr));
        chk("ramp_value", 64'(outRed), 64'(XS));
      end
    end
    if (outLineStart === 1'b1) ls_seen++;
    if (outFrameStart === 1'b1) fs_seen++;
  endtask

  // driver: one pixel per clock, outputs checked #1 after the edge
  task automatic drive_pixel(input logic hs, input logic vs, input logic [9:0] r);
    logic [W-1:0] e;
    logic [9:0] g, b;
    g = 10'($urandom_range(1023, 0));
    b = 10'($urandom_range(1023, 0));
    in_H_SYNC = hs; in_V_SYNC = vs; inRed = r; inGreen = g; inBlue = b;
    model_pixel(hs, vs, r, g, b, e);
    exp_q.push_back(e);
    pin_red_q.push_back(r);
    @(posedge iCLK);
    #1;
    if (exp_q.size() == 2) check_out();
  endtask

  task automatic do_line(input int len, input int vfall_px);
    logic [9:0] r;
    for (int px = 0; px < len; px++) begin
      if (px == vfall_px) cur_vs = 1'b0;
      r = ramp_mode ? px[9:0] : 10'($urandom_range(1023, 0));
      drive_pixel((px < HSW) ? 1'b0 : 1'b1, cur_vs, r);
    end
  endtask

  task automatic do_frame(input int voff, input int short_line, input int nlines);
    for (int ln = 0; ln < nlines; ln++) begin
      if (ln == VSW) cur_vs = 1'b1;
      do_line((ln == short_line) ? HT - 1 : HT, (ln == 0) ? voff : -1);
    end
  endtask

  task automatic clear_stats();
    valid_seen = 0; ls_seen = 0; fs_seen = 0; ramp_checks = 0; first_seen = 0;
  endtask

  task automatic release_reset();
    iRST_N = 1'b1;
    model_reset();
    exp_q.delete();
    pin_red_q.delete();
    cur_vs = 1'b1;
  endtask

  initial begin
    logic [W-1:0] zero_v;
    zero_v = '0;
    clear_stats();
    ramp_mode = 0;
    // power-on reset
    repeat (3) @(posedge iCLK);
    #1;
    chk("reset_outputs", 64'({outValid, outLineStart, outFrameStart, outLocked,
                              outX, outY, outRed, outGreen, outBlue}), 64'(zero_v));
    release_reset();

    // three standard frames: lock after the 2nd V fall, full window in frame 3
    do_frame(0, -1, VT);
    chk("unlocked_after_1_vfall", 64'(outLocked), 64'(0));
    do_frame(0, -1, VT);
    chk("locked_after_2_vfalls", 64'(outLocked), 64'(1));
    clear_stats();
    do_frame(0, -1, VT);
    chk("frame3_valid_count", 64'(valid_seen), 64'(HA * VA));
    chk("frame3_line_starts", 64'(ls_seen), 64'(VA));
    chk("frame3_frame_starts", 64'(fs_seen), 64'(1));
    chk("first_pulse_x", 64'(first_x), 64'(0));
    chk("first_pulse_y", 64'(first_y), 64'(0));
    chk("first_pulse_fs", 64'(first_fs), 64'(1));

    // RGB ramp: red equals the pixel's H position on the pins
    clear_stats();
    ramp_mode = 1;
    do_frame(0, -1, VT);
    ramp_mode = 0;
    chk("ramp_lines_seen", 64'(ramp_checks), 64'(VA));

    // V fall mid-line: frame origin moves to the following H fall
    clear_stats();
    do_frame(10, -1, VT);
    do_frame(0, -1, VT);
    chk("midline_vfall_frame_starts", 64'(fs_seen), 64'(2));
    chk("midline_vfall_locked", 64'(outLocked), 64'(1));

    // one short (HT-1) line while locked keeps lock in this build
    do_frame(0, 5, VT);
    chk("short_line_locked", 64'(outLocked), 64'(1));

    // hsync lost for 5000 clocks
    clear_stats();
    for (int k = 0; k < 5000; k++) begin
      drive_pixel(1'b1, 1'b1, 10'($urandom_range(1023, 0)));
      if (k == 3990) chk("hold_still_locked", 64'(outLocked), 64'(1));
    end
    chk("hold_lock_lost", 64'(outLocked), 64'(0));
    chk("hold_no_valid", 64'(valid_seen), 64'(0));
    do_frame(0, -1, VT);
    do_frame(0, -1, VT);
    chk("relock_after_loss", 64'(outLocked), 64'(1));

    // reset mid-frame inside the active window
    do_frame(0, -1, 5);
    for (int px = 0; px < 12; px++)
      drive_pixel((px < HSW) ? 1'b0 : 1'b1, 1'b1, 10'($urandom_range(1023, 0)));
    chk("valid_before_reset", 64'(outValid), 64'(1));
    #2;
    iRST_N = 1'b0;
    in_H_SYNC = 1'b1;
    in_V_SYNC = 1'b1;
    #1;
    chk("reset_mid_frame_outputs", 64'({outValid, outLineStart, outFrameStart, outLocked,
                                        outX, outY, outRed, outGreen, outBlue}), 64'(zero_v));
    repeat (2) @(posedge iCLK);
    #1;
    release_reset();
    clear_stats();
    do_frame(0, -1, VT);
    chk("post_reset_no_line_start", 64'(ls_seen), 64'(0));
    chk("post_reset_not_locked", 64'(outLocked), 64'(0));
    clear_stats();
    do_frame(0, -1, VT);
    chk("post_reset_relocked", 64'(outLocked), 64'(1));
    chk("post_reset_valid_count", 64'(valid_seen), 64'(HA * VA));
    do_frame(0, -1, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
